mem_bus_sequencer: RTL

- Sequences CPU memory requests onto the two-bank (odd/even byte) RAM through its BHE/A0/RD/WR/WRE strobe interface.
- Generates T1–T4 bus cycles with configurable wait states.
- Steers bytes between the CPU data word and the RAM lanes.
- Splits odd-address word accesses into two byte cycles.
- Sits between the execution unit's memory request port and the RAM bank strobe decoder.

---
 rtl/mem_bus_sequencer.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/mem_bus_sequencer.sv
// Sequences CPU byte/word requests into T1-T4 bus cycles on the odd/even bank RAM,
// steering bytes between CPU and RAM lanes; odd-address words become two byte phases.
module mem_bus_sequencer #(
  parameter int ADDR_W      = 20,
  parameter int WAIT_STATES = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              we,
  input  logic              word,
  input  logic [ADDR_W-1:0] addr,
  input  logic [15:0]       wdata,
  output logic              busy,
  output logic              ready,
  output logic [15:0]       rdata,
  output logic [ADDR_W-1:0] ADDR,
  output logic              BHE,
  output logic              A0,
  output logic              RD,
  output logic              WR,
  output logic              WRE,
  output logic [15:0]       DOUT,
  input  logic [15:0]       DIN
);

  typedef enum logic [2:0] {IDLE, T1, T2, TW, T3, T4} state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] a;
    logic              bhe;
    logic              a0;
    logic [15:0]       d;
  } phase_t;

  localparam logic [2:0] WS = 3'(WAIT_STATES);

  state_t            state;
  logic              we_q;
  logic              word_q;
  logic [ADDR_W-1:0] addr_q;
  logic [15:0]       wdata_q;
  logic              second;
  logic [2:0]        wcnt;
  logic [7:0]        rlo;
  logic              split;
  phase_t            p_first;
  phase_t            p_second;

  // Bus-side address, bank selects and lane placement for one phase of an access.
  function automatic phase_t plan(input logic [ADDR_W-1:0] a, input logic wd,
                                  input logic [15:0] d, input logic sec);
    phase_t p;
    p.a   = a;
    p.bhe = 1'b1;
    p.a0  = 1'b0;
    p.d   = {8'h00, d[7:0]};
    if (wd && !a[0]) begin
      p.bhe = 1'b0;
      p.d   = d;
    end else if (wd && sec) begin
      p.a = a + ADDR_W'(1);
      p.d = {8'h00, d[15:8]};
    end else if (a[0]) begin
      p.bhe = 1'b0;
      p.a0  = 1'b1;
      p.d   = {d[7:0], 8'h00};
    end
    return p;
  endfunction

  assign split    = word_q & addr_q[0];
  assign p_first  = plan(addr, word, wdata, 1'b0);
  assign p_second = plan(addr_q, word_q, wdata_q, 1'b1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      we_q    <= 1'b0;
      word_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= 16'h0000;
      second  <= 1'b0;
      wcnt    <= 3'd0;
      rlo     <= 8'h00;
      busy    <= 1'b0;
      ready   <= 1'b0;
      rdata   <= 16'h0000;
      ADDR    <= '0;
      BHE     <= 1'b1;
      A0      <= 1'b1;
      RD      <= 1'b0;
      WR      <= 1'b0;
      WRE     <= 1'b0;
      DOUT    <= 16'h0000;
    end else begin
      ready <= 1'b0;
      case (state)
        IDLE: begin
          RD  <= 1'b0;
          WR  <= 1'b0;
          WRE <= 1'b0;
          BHE <= 1'b1;
          A0  <= 1'b1;
          if (req) begin
            we_q    <= we;
            word_q  <= word;
            addr_q  <= addr;
            wdata_q <= wdata;
            second  <= 1'b0;
            busy    <= 1'b1;
            ADDR    <= p_first.a;
            BHE     <= p_first.bhe;
            A0      <= p_first.a0;
            DOUT    <= p_first.d;
            state   <= T1;
          end
        end
        T1: begin
          RD    <= ~we_q;
          WR    <= we_q;
          state <= T2;
        end
        T2: begin
          if (WS != 3'd0) begin
            wcnt  <= WS - 3'd1;
            state <= TW;
          end else begin
            WRE   <= we_q;
            state <= T3;
          end
        end
        TW: begin
          if (wcnt == 3'd0) begin
            WRE   <= we_q;
            state <= T3;
          end else begin
            wcnt <= wcnt - 3'd1;
          end
        end
        T3: begin
          RD    <= 1'b0;
          WR    <= 1'b0;
          WRE   <= 1'b0;
          state <= T4;
          // The first half of a split read is parked so rdata only changes once the whole word is in.
          if (!we_q) begin
            if (word_q && !addr_q[0])  rdata <= DIN;
            else if (split && !second) rlo   <= DIN[15:8];
            else if (split)            rdata <= {DIN[7:0], rlo};
            else if (addr_q[0])        rdata <= {8'h00, DIN[15:8]};
            else                       rdata <= {8'h00, DIN[7:0]};
          end
          if (!(split && !second)) ready <= 1'b1;
        end
        T4: begin
          if (split && !second) begin
            second <= 1'b1;
            ADDR   <= p_second.a;
            BHE    <= p_second.bhe;
            A0     <= p_second.a0;
            DOUT   <= p_second.d;
            state  <= T1;
          end else begin
            busy  <= 1'b0;
            BHE   <= 1'b1;
            A0    <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
